// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: arbiter state/grant encodings, address width and
// controller command codes used across the SDRAM blocks.
package sdram_pkg;

    localparam int unsigned SDRAM_ADDR_W = 20;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2,
        GAP      = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_e;

    // Encoded as {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_LOAD_MODE  = 4'b0000,
        CMD_REFRESH    = 4'b0001,
        CMD_PRECHARGE  = 4'b0010,
        CMD_ACTIVE     = 4'b0011,
        CMD_WRITE      = 4'b0100,
        CMD_READ       = 4'b0101,
        CMD_BURST_STOP = 4'b0110,
        CMD_NOP        = 4'b0111,
        CMD_DESELECT   = 4'b1111
    } sdram_cmd_e;

endpackage

// File: rtl/sdram_rw_arbiter_if.sv
// Bundle between the burst arbiter, the two data FIFOs and the SDRAM controller.
// master = arbiter side, slave = FIFO/controller side.
interface sdram_rw_arbiter_if #(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned FIFO_DW = 10
);
    logic               ctrl_ready;
    logic [FIFO_DW-1:0] wr_fifo_usedw;
    logic [FIFO_DW-1:0] rd_fifo_usedw;
    logic               wr_restart;
    logic               rd_restart;
    logic               write_req;
    logic               read_req;
    logic               write_ack;
    logic               read_ack;
    logic [ADDR_W-1:0]  sdram_addr;
    logic               busy;
    logic               err_timeout;

    modport master (
        input  ctrl_ready, wr_fifo_usedw, rd_fifo_usedw, wr_restart, rd_restart,
        input  write_ack, read_ack,
        output write_req, read_req, sdram_addr, busy, err_timeout
    );

    modport slave (
        output ctrl_ready, wr_fifo_usedw, rd_fifo_usedw, wr_restart, rd_restart,
        output write_ack, read_ack,
        input  write_req, read_req, sdram_addr, busy, err_timeout
    );
endinterface

// File: rtl/sdram_addr_ptr.sv
// Circular burst address pointer for one channel. A restart that arrives while
// the channel's burst is outstanding is parked until the burst ends.
module sdram_addr_ptr #(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned BASE      = 0,
    parameter int unsigned LIMIT     = 32'h80000,
    parameter int unsigned BURST_LEN = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              advance_i,
    input  logic              restart_i,
    input  logic              hold_i,
    output logic [ADDR_W-1:0] ptr_o
);
    localparam int unsigned XW = ADDR_W + 1;
    localparam logic [XW-1:0] BASE_X  = XW'(BASE);
    localparam logic [XW-1:0] LIMIT_X = XW'(LIMIT);
    localparam logic [XW-1:0] STEP_X  = XW'(BURST_LEN);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              latch_q, latch_d;
    logic [XW-1:0]     next_x;

    always_comb begin
        next_x  = {1'b0, ptr_q} + STEP_X;
        ptr_d   = ptr_q;
        latch_d = latch_q;
        if (hold_i) begin
            // Burst ends on advance (ack); on a timeout hold simply drops and
            // the parked restart is applied in the branch below.
            if (advance_i) begin
                latch_d = 1'b0;
                if (latch_q || restart_i) begin
                    ptr_d = BASE_X[ADDR_W-1:0];
                end else if (next_x >= LIMIT_X) begin
                    ptr_d = BASE_X[ADDR_W-1:0];
                end else begin
                    ptr_d = next_x[ADDR_W-1:0];
                end
            end else if (restart_i) begin
                latch_d = 1'b1;
            end
        end else if (latch_q || restart_i) begin
            ptr_d   = BASE_X[ADDR_W-1:0];
            latch_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q   <= BASE_X[ADDR_W-1:0];
            latch_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            latch_q <= latch_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sdram_rw_arbiter.sv
// Full-page burst scheduler between the write/read FIFOs and the SDRAM controller.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no burst outstanding; grant write/read when pending
// WR_BURST | write_req high, waiting for write_ack or timeout
// RD_BURST | read_req high, waiting for read_ack or timeout
// GAP      | one cycle with req low so the controller can leave its burst
module sdram_rw_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W      = SDRAM_ADDR_W,
    parameter int unsigned FIFO_DW     = 10,
    parameter int unsigned BURST_LEN   = 256,
    parameter int unsigned WR_BASE     = 32'h00000,
    parameter int unsigned WR_LIMIT    = 32'h80000,
    parameter int unsigned RD_BASE     = 32'h00000,
    parameter int unsigned RD_LIMIT    = 32'h80000,
    parameter int unsigned WR_THRESH   = 256,
    parameter int unsigned RD_THRESH   = 256,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic               S_CLK,
    input  logic               RST,
    sdram_rw_arbiter_if.master bus
);
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [FIFO_DW:0] WR_TH    = (FIFO_DW + 1)'(WR_THRESH);
    localparam logic [FIFO_DW:0] RD_TH    = (FIFO_DW + 1)'(RD_THRESH);

    arb_state_e        state_q, state_d;
    grant_e            last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic              wr_pend, rd_pend;
    logic              in_wr, in_rd;
    logic              wr_adv, rd_adv;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;

    assign wr_pend = bus.ctrl_ready & ({1'b0, bus.wr_fifo_usedw} >= WR_TH);
    assign rd_pend = bus.ctrl_ready & ({1'b0, bus.rd_fifo_usedw} <  RD_TH);
    assign in_wr   = (state_q == WR_BURST);
    assign in_rd   = (state_q == RD_BURST);
    assign wr_adv  = in_wr & bus.write_ack;
    assign rd_adv  = in_rd & bus.read_ack;

    sdram_addr_ptr #(
        .ADDR_W   (ADDR_W),
        .BASE     (WR_BASE),
        .LIMIT    (WR_LIMIT),
        .BURST_LEN(BURST_LEN)
    ) u_wr_ptr (
        .clk_i    (S_CLK),
        .rst_i    (RST),
        .advance_i(wr_adv),
        .restart_i(bus.wr_restart),
        .hold_i   (in_wr),
        .ptr_o    (wr_ptr)
    );

    sdram_addr_ptr #(
        .ADDR_W   (ADDR_W),
        .BASE     (RD_BASE),
        .LIMIT    (RD_LIMIT),
        .BURST_LEN(BURST_LEN)
    ) u_rd_ptr (
        .clk_i    (S_CLK),
        .rst_i    (RST),
        .advance_i(rd_adv),
        .restart_i(bus.rd_restart),
        .hold_i   (in_rd),
        .ptr_o    (rd_ptr)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // On contention the channel that did not win last time goes first
                if (wr_pend && (!rd_pend || last_q == GRANT_READ)) begin
                    state_d = WR_BURST;
                    addr_d  = wr_ptr;
                end else if (rd_pend) begin
                    state_d = RD_BURST;
                    addr_d  = rd_ptr;
                end
            end
            WR_BURST, RD_BURST: begin
                if (wr_adv || rd_adv) begin
                    state_d = GAP;
                    last_d  = in_wr ? GRANT_WRITE : GRANT_READ;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = GAP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge S_CLK) begin
        if (RST) begin
            state_q <= IDLE;
            last_q  <= GRANT_READ;
            cnt_q   <= '0;
            addr_q  <= ADDR_W'(WR_BASE);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign bus.write_req   = in_wr;
    assign bus.read_req    = in_rd;
    assign bus.busy        = in_wr | in_rd;
    assign bus.sdram_addr  = addr_q;
    assign bus.err_timeout = err_q;

endmodule

// File: doc/sdram_rw_arbiter.md
Name: sdram_rw_arbiter

Overview:
- Burst scheduler between the two data FIFOs (write-side fill FIFO, read-side drain FIFO) and the SDRAM controller top.
- Decides when a full-page write burst or read burst is needed, raises write_req/read_req, and holds sdram_addr stable for the whole burst.
- Advances per-channel circular address pointers on each burst acknowledge.
- Arbitrates round-robin when both channels are pending. Recovers from a missing acknowledge via timeout.

Parameters:
- ADDR_W, 20, SDRAM word address width (12 row + 8 column, bank fixed).
- FIFO_DW, 10, width of the FIFO used-word counts.
- BURST_LEN, 256, words per burst; power of two.
- WR_BASE, 20'h00000, first address of the write region.
- WR_LIMIT, 20'h80000, exclusive end of the write region; multiple of BURST_LEN.
- RD_BASE, 20'h00000, first address of the read region.
- RD_LIMIT, 20'h80000, exclusive end of the read region.
- WR_THRESH, 256, write burst needed when wr_fifo_usedw >= WR_THRESH.
- RD_THRESH, 256, read burst needed when rd_fifo_usedw < RD_THRESH.
- TIMEOUT_CYC, 4096, max cycles from request to acknowledge.

Ports:
- S_CLK, in, 1, system clock.
- RST, in, 1, reset. Synchronous, active-high.
- ctrl_ready, in, 1, SDRAM controller initialisation complete.
- wr_fifo_usedw, in, FIFO_DW, words currently in the write FIFO.
- rd_fifo_usedw, in, FIFO_DW, words currently in the read FIFO.
- wr_restart, in, 1, pulse: rewind the write pointer to WR_BASE.
- rd_restart, in, 1, pulse: rewind the read pointer to RD_BASE.
- write_req, out, 1, write burst request to the controller.
- read_req, out, 1, read burst request to the controller.
- write_ack, in, 1, controller write-burst-done.
- read_ack, in, 1, controller read-burst-done.
- sdram_addr, out, ADDR_W, burst start address to the controller.
- busy, out, 1, a burst is outstanding.
- err_timeout, out, 1, sticky flag: an acknowledge timed out.

Behaviour:
- Reset (RST=1 at an S_CLK edge, including mid-burst): state=IDLE, write_req=0, read_req=0, busy=0, err_timeout=0, wr_ptr=WR_BASE, rd_ptr=RD_BASE, sdram_addr=WR_BASE, last_grant=READ, restart latches=0, timeout counter=0. Any outstanding burst is abandoned.
- Pending conditions (all compares unsigned):
  - wr_pend = ctrl_ready & (wr_fifo_usedw >= WR_THRESH)
  - rd_pend = ctrl_ready & (rd_fifo_usedw < RD_THRESH)
- State IDLE:
  - Only wr_pend: go to WR_BURST.
  - Only rd_pend: go to RD_BURST.
  - Both pending: grant the channel not equal to last_grant.
  - On grant, in the same registered edge: set the matching req=1, busy=1, and sdram_addr=wr_ptr or rd_ptr. Latency from pending to req is 1 cycle.
- State WR_BURST / RD_BURST:
  - req and sdram_addr held constant; timeout counter increments.
  - First cycle the matching ack=1:
    - Drop req on the next edge and go to GAP.
    - Update last_grant.
    - Advance the pointer: next = ptr + BURST_LEN; if next >= LIMIT then next = BASE.
  - A pending restart latch overrides the advance: ptr = BASE, latch cleared.
  - The opposite channel's ack is ignored.
- Timeout: counter reaches TIMEOUT_CYC-1 without ack -> drop req, err_timeout=1, go to GAP. Pointer is not advanced; the burst is retried later.
- State GAP:
  - Exactly 1 cycle, req=0, busy=0.
  - Guarantees the controller sees req low with ack high so it can leave its burst state and service refresh.
  - Acks arriving in GAP or IDLE are ignored.
  - Then go to IDLE.
- Restart rules:
  - wr_restart / rd_restart in IDLE or GAP: pointer := BASE on the next edge.
  - Restart during that channel's burst: latched and applied at ack or timeout.
  - Restart during the other channel's burst: applied immediately.
- ctrl_ready=0 blocks new grants only; an outstanding burst completes normally.
- sdram_addr keeps its last value outside bursts.
- err_timeout is cleared only by RST.

Decomposition:
- Shared package sdram_pkg holds:
  - state encoding (IDLE, WR_BURST, RD_BURST, GAP);
  - grant encoding (WRITE, READ);
  - ADDR_W;
  - controller command constants reused by other SDRAM blocks.
- One sub-module, sdram_addr_ptr, instantiated twice (write and read):
  - parameters BASE, LIMIT, BURST_LEN;
  - inputs advance, restart, hold;
  - output ptr;
  - contains the wrap and restart-latch logic.

Test Plan:
- Reset: hold RST=1 for 3 cycles -> write_req=0, read_req=0, busy=0, err_timeout=0, sdram_addr=20'h00000.
- Single write burst: ctrl_ready=1, wr_fifo_usedw=300, rd_fifo_usedw=512.
  - write_req=1 one cycle later with sdram_addr=0x00000.
  - Pulse write_ack -> write_req=0 next cycle, 1-cycle GAP.
  - Next write burst uses sdram_addr=0x00100.
- Contention: wr_fifo_usedw=300 and rd_fifo_usedw=10 held constant -> grants alternate W, R, W, R (write first after reset). Addresses are 0x00000 / 0x00000 / 0x00100 / 0x00100.
- Wrap: WR_LIMIT=20'h00400, run 4 write bursts -> addresses 0x000, 0x100, 0x200, 0x300; the fifth burst is at 0x000.
- Timeout and restart:
  - TIMEOUT_CYC=16 with no ack -> write_req falls after 16 cycles, err_timeout=1, retry at the same address.
  - Pulse wr_restart mid-burst at address 0x200, then ack -> next write address is 0x000, not 0x300.
